// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive-side frame path.
package uart_pkg;

  // Frame controller states, encoding fixed so other blocks can decode them.
  typedef enum logic [2:0] {
    HUNT    = 3'd0,
    LEN     = 3'd1,
    PAYLOAD = 3'd2,
    CSUM    = 3'd3,
    DRAIN   = 3'd4
  } frame_state_e;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;
  localparam logic [7:0] MAX_LEN   = 8'd8;

  // A length byte is usable only if it names between 1 and MAX_LEN payload bytes.
  function automatic logic len_ok(input logic [7:0] len_byte);
    return (len_byte != 8'd0) && (len_byte <= MAX_LEN);
  endfunction

endpackage

// File: rtl/uart_frame_ctrl.sv
// Receive-side frame controller: sync hunt, length-prefixed payload capture,
// additive checksum check, and replay of good frames over a valid/ready stream.
module uart_frame_ctrl
  import uart_pkg::*;
#(
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic       clk_br,
  input  logic       rst,
  input  logic       rx_done,
  input  logic [7:0] rx_data,
  output logic       out_valid,
  output logic [7:0] out_data,
  output logic       out_last,
  input  logic       out_ready,
  output logic       crc_err,
  output logic       len_err,
  output logic       timeout,
  output logic       overrun
);

  localparam int GAP_W = $clog2(TIMEOUT);
  localparam logic [GAP_W-1:0] GAP_MAX = GAP_W'(TIMEOUT - 1);

  frame_state_e state, state_n;

  logic             rx_done_q;
  logic             byte_ev;
  logic [3:0]       len;
  logic [3:0]       idx;
  logic [7:0]       sum;
  logic [GAP_W-1:0] gap;
  logic [7:0]       frame_buf [MAX_LEN];

  logic in_frame;
  logic gap_expire;
  logic xfer;
  logic len_bad;
  logic sum_bad;
  logic byte_dropped;

  // A byte counts only on the rising edge of the receiver's done level.
  assign byte_ev  = rx_done && !rx_done_q;
  assign in_frame = (state == LEN) || (state == PAYLOAD) || (state == CSUM);

  assign out_valid = (state == DRAIN);
  assign out_data  = out_valid ? frame_buf[idx[2:0]] : 8'h00;
  assign out_last  = out_valid && (idx == len - 4'd1);
  assign xfer      = out_valid && out_ready;

  // State register; reset always returns to hunting for a sync byte.
  always_ff @(posedge clk_br) begin
    if (rst) begin
      state <= HUNT;
    end else begin
      state <= state_n;
    end
  end

  // Next-state decode and detection of the conditions that raise status pulses.
  always_comb begin
    state_n      = state;
    len_bad      = 1'b0;
    sum_bad      = 1'b0;
    byte_dropped = 1'b0;
    gap_expire   = in_frame && (gap == GAP_MAX) && !byte_ev;
    case (state)
      HUNT: begin
        if (byte_ev && (rx_data == SYNC_BYTE)) state_n = LEN;
      end
      LEN: begin
        if (byte_ev) begin
          if (len_ok(rx_data)) begin
            state_n = PAYLOAD;
          end else begin
            len_bad = 1'b1;
            state_n = HUNT;
          end
        end else if (gap_expire) begin
          state_n = HUNT;
        end
      end
      PAYLOAD: begin
        if (byte_ev) begin
          if (idx == len - 4'd1) state_n = CSUM;
        end else if (gap_expire) begin
          state_n = HUNT;
        end
      end
      CSUM: begin
        if (byte_ev) begin
          if (rx_data == sum) begin
            state_n = DRAIN;
          end else begin
            sum_bad = 1'b1;
            state_n = HUNT;
          end
        end else if (gap_expire) begin
          state_n = HUNT;
        end
      end
      DRAIN: begin
        byte_dropped = byte_ev;
        if (xfer && out_last) state_n = HUNT;
      end
      default: state_n = HUNT;
    endcase
  end

  // Datapath: edge detector, gap counter, length/checksum/index tracking and status pulses.
  always_ff @(posedge clk_br) begin
    if (rst) begin
      rx_done_q <= 1'b1;
      len       <= 4'd0;
      idx       <= 4'd0;
      sum       <= 8'd0;
      gap       <= '0;
      crc_err   <= 1'b0;
      len_err   <= 1'b0;
      timeout   <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      rx_done_q <= rx_done;
      crc_err   <= sum_bad;
      len_err   <= len_bad;
      timeout   <= gap_expire;
      overrun   <= byte_dropped;

      if (byte_ev || (state_n != state) || !in_frame) begin
        gap <= '0;
      end else begin
        gap <= gap + GAP_W'(1);
      end

      case (state)
        LEN: begin
          if (byte_ev && len_ok(rx_data)) begin
            len <= rx_data[3:0];
            sum <= rx_data;
            idx <= 4'd0;
          end
        end
        PAYLOAD: begin
          if (byte_ev) begin
            sum <= sum + rx_data;
            idx <= idx + 4'd1;
          end
        end
        CSUM: begin
          if (byte_ev && (rx_data == sum)) idx <= 4'd0;
        end
        DRAIN: begin
          if (xfer) idx <= idx + 4'd1;
        end
        default: ;
      endcase
    end
  end

  // Payload buffer; contents only matter once a checksum has been accepted.
  always_ff @(posedge clk_br) begin
    if ((state == PAYLOAD) && byte_ev) begin
      frame_buf[idx[2:0]] <= rx_data;
    end
  end

endmodule

// File: tb/tb_uart_frame_ctrl.sv
// Self-checking bench for uart_frame_ctrl: table of directed frames, hand-written
// corner sequences and randomized frames scored against a frame-level model.
module tb_uart_frame_ctrl;

  localparam int TIMEOUT = 1024;
  localparam int CLK_P   = 10;
  localparam logic [7:0] SYNC = 8'hA5;

  typedef struct {
    logic [95:0] bytes;
    int          nbytes;
    logic [63:0] exp_out;
    int          nexp;
    int          exp_crc;
    int          exp_len;
  } vec_t;

  logic       clk_br    = 1'b0;
  logic       rst       = 1'b1;
  logic       rx_done   = 1'b0;
  logic [7:0] rx_data   = 8'h00;
  logic       out_ready = 1'b1;
  logic       out_valid, out_last, crc_err, len_err, timeout, overrun;
  logic [7:0] out_data;

  int checks = 0;
  int errors = 0;
  int got_crc = 0, got_len = 0, got_to = 0, got_ovr = 0;
  int exp_crc = 0, exp_len = 0, exp_to = 0, exp_ovr = 0;
  int nxfer = 0;
  int ready_mode = 0;
  time last_ev_t, crc_t, len_t, to_t, ovr_t, first_xfer_t, last_xfer_t;
  logic [8:0] exp_q [$];
  logic       stall_q = 1'b0;
  logic [8:0] stall_val;
  vec_t       vecs [8];

  uart_frame_ctrl #(.TIMEOUT(TIMEOUT)) dut (
    .clk_br   (clk_br),
    .rst      (rst),
    .rx_done  (rx_done),
    .rx_data  (rx_data),
    .out_valid(out_valid),
    .out_data (out_data),
    .out_last (out_last),
    .out_ready(out_ready),
    .crc_err  (crc_err),
    .len_err  (len_err),
    .timeout  (timeout),
    .overrun  (overrun)
  );

  always #(CLK_P/2) clk_br = ~clk_br;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0d required=%0d", name, actual, expected);
    end
  endtask

  // Monitor on the falling edge: pulse counting, stream stability and scoreboard.
  always @(negedge clk_br) begin
    logic [8:0] e;
    if (rst) begin
      stall_q = 1'b0;
    end else begin
      if (crc_err) begin got_crc++; crc_t = $time; end
      if (len_err) begin got_len++; len_t = $time; end
      if (timeout) begin got_to++;  to_t  = $time; end
      if (overrun) begin got_ovr++; ovr_t = $time; end
      if (stall_q) begin
        checkOutput("stall_valid", int'(out_valid), 1);
        checkOutput("stall_last_data", int'({out_last, out_data}), int'(stall_val));
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checkOutput("unexpected_xfer", int'(out_data), -1);
        end else begin
          e = exp_q.pop_front();
          checkOutput("xfer_data", int'(out_data), int'(e[7:0]));
          checkOutput("xfer_last", int'(out_last), int'(e[8]));
        end
        if (nxfer == 0) first_xfer_t = $time;
        last_xfer_t = $time;
        nxfer++;
      end
      stall_q   = out_valid && !out_ready;
      stall_val = {out_last, out_data};
    end
  end

  // Consumer handshake driver: 0 = held by the main sequence, 1 = random, 2 = toggling.
  initial forever begin
    @(posedge clk_br);
    #1;
    if (ready_mode == 1) out_ready = 1'($urandom_range(0, 1));
    else if (ready_mode == 2) out_ready = !out_ready;
  end

  initial begin
    #(200000 * CLK_P);
    $display("[TB] FAIL watchdog actual=running required=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic setReady(input int mode, input logic r);
    ready_mode = mode;
    out_ready  = r;
  endtask

  task automatic idleCycles(input int n);
    repeat (n) begin
      @(posedge clk_br);
      #1;
    end
  endtask

  task automatic sendByte(input logic [7:0] b);
    rx_data = b;
    rx_done = 1'b1;
    @(posedge clk_br);
    last_ev_t = $time;
    #1 rx_done = 1'b0;
    @(posedge clk_br);
    #1;
  endtask

  task automatic pushFrame(input logic [7:0] d0, input logic [7:0] d1, input int n);
    exp_q.push_back({1'(n == 1), d0});
    if (n > 1) exp_q.push_back({1'b1, d1});
  endtask

  task automatic waitDrain(input int bound);
    for (int k = 0; k < bound && exp_q.size() != 0; k++) idleCycles(1);
    idleCycles(2);
  endtask

  task automatic checkCounts(input string tag);
    checkOutput({tag, "_crc_cnt"}, got_crc, exp_crc);
    checkOutput({tag, "_len_cnt"}, got_len, exp_len);
    checkOutput({tag, "_to_cnt"},  got_to,  exp_to);
    checkOutput({tag, "_ovr_cnt"}, got_ovr, exp_ovr);
    checkOutput({tag, "_drained"}, exp_q.size(), 0);
  endtask

  task automatic applyStimulus(input vec_t vv);
    for (int i = 0; i < vv.nexp; i++) exp_q.push_back({1'(i == vv.nexp - 1), vv.exp_out[63-8*i -: 8]});
    exp_crc += vv.exp_crc;
    exp_len += vv.exp_len;
    nxfer = 0;
    for (int i = 0; i < vv.nbytes; i++) sendByte(vv.bytes[95-8*i -: 8]);
    idleCycles(12);
  endtask

  initial begin
    vecs[0] = '{96'hA50311223369_000000000000, 6,  64'h112233_0000000000, 3, 0, 0};
    vecs[1] = '{96'h00FFA502010200_0000000000, 7,  64'h0,                 0, 1, 0};
    vecs[2] = '{96'hA5017E7F_0000000000000000, 4,  64'h7E_00000000000000, 1, 0, 0};
    vecs[3] = '{96'hA5017E7E_0000000000000000, 4,  64'h0,                 0, 1, 0};
    vecs[4] = '{96'hA500_00000000000000000000, 2,  64'h0,                 0, 0, 1};
    vecs[5] = '{96'hA509_00000000000000000000, 2,  64'h0,                 0, 0, 1};
    vecs[6] = '{96'hA50801020304050607082C_00, 11, 64'h0102030405060708,  8, 0, 0};
    vecs[7] = '{96'hA502AABB67_00000000000000, 5,  64'hAABB_000000000000, 2, 0, 0};

    // Reset state.
    repeat (3) @(posedge clk_br);
    #1;
    checkOutput("rst_out_valid", int'(out_valid), 0);
    checkOutput("rst_out_data",  int'(out_data), 0);
    checkOutput("rst_out_last",  int'(out_last), 0);
    checkOutput("rst_pulses",    int'({crc_err, len_err, timeout, overrun}), 0);
    rst = 1'b0;
    idleCycles(2);

    // Directed frame table, consumer always ready.
    for (int v = 0; v < 8; v++) begin
      applyStimulus(vecs[v]);
      checkOutput($sformatf("vec%0d_drained", v), exp_q.size(), 0);
      checkOutput($sformatf("vec%0d_nxfer", v), nxfer, vecs[v].nexp);
      if (vecs[v].exp_crc != 0) checkOutput($sformatf("vec%0d_crc_time", v), int'(crc_t - last_ev_t), CLK_P/2);
      if (vecs[v].exp_len != 0) checkOutput($sformatf("vec%0d_len_time", v), int'(len_t - last_ev_t), CLK_P/2);
      if (vecs[v].nexp != 0) begin
        checkOutput($sformatf("vec%0d_latency", v), int'(first_xfer_t - last_ev_t), CLK_P/2);
        checkOutput($sformatf("vec%0d_span", v), int'(last_xfer_t - first_xfer_t), (vecs[v].nexp - 1) * CLK_P);
      end
    end
    checkCounts("table");

    // Toggling backpressure on the 3-byte frame.
    setReady(2, 1'b1);
    pushFrame(8'h11, 8'h22, 2);
    exp_q.push_back({1'b1, 8'h33});
    exp_q[1] = {1'b0, 8'h22};
    sendByte(8'hA5); sendByte(8'h03); sendByte(8'h11); sendByte(8'h22); sendByte(8'h33); sendByte(8'h69);
    waitDrain(40);
    setReady(0, 1'b1);
    checkCounts("toggle");

    // A byte event in the cycle right after the last transfer is processed.
    pushFrame(8'h7E, 8'h00, 1);
    pushFrame(8'h42, 8'h00, 1);
    sendByte(8'hA5); sendByte(8'h01); sendByte(8'h7E); sendByte(8'h7F);
    sendByte(8'hA5); sendByte(8'h01); sendByte(8'h42); sendByte(8'h43);
    waitDrain(20);
    checkCounts("back2back");

    // Inter-byte timeout and the boundary where the byte wins.
    nxfer = 0;
    sendByte(8'hA5); sendByte(8'h02); sendByte(8'h01);
    begin
      time t0;
      t0 = last_ev_t;
      idleCycles(TIMEOUT + 20);
      exp_to++;
      checkOutput("timeout_time", int'(to_t - t0), TIMEOUT * CLK_P + CLK_P/2);
    end
    checkOutput("timeout_no_out", nxfer, 0);
    pushFrame(8'h01, 8'h02, 2);
    sendByte(8'hA5); sendByte(8'h02); sendByte(8'h01);
    idleCycles(TIMEOUT - 2);
    sendByte(8'h02); sendByte(8'h05);
    waitDrain(20);
    checkCounts("timeout");

    // Overrun while the consumer stalls.
    setReady(0, 1'b0);
    pushFrame(8'hAA, 8'hBB, 2);
    sendByte(8'hA5); sendByte(8'h02); sendByte(8'hAA); sendByte(8'hBB); sendByte(8'h67);
    idleCycles(3);
    checkOutput("ovr_pre_valid", int'(out_valid), 1);
    checkOutput("ovr_pre_data", int'(out_data), 8'hAA);
    sendByte(8'h55);
    exp_ovr++;
    checkOutput("ovr_time", int'(ovr_t - last_ev_t), CLK_P/2);
    checkOutput("ovr_post_data", int'(out_data), 8'hAA);
    setReady(0, 1'b1);
    waitDrain(20);
    checkCounts("overrun");

    // Reset mid-payload abandons the frame.
    nxfer = 0;
    sendByte(8'hA5); sendByte(8'h04); sendByte(8'h01); sendByte(8'h02);
    rst = 1'b1;
    idleCycles(1);
    rst = 1'b0;
    idleCycles(2);
    sendByte(8'h03); sendByte(8'h04); sendByte(8'h0E);
    idleCycles(6);
    checkOutput("rst_payload_no_out", nxfer, 0);

    // Reset mid-drain with rx_done held high across release.
    setReady(0, 1'b0);
    sendByte(8'hA5); sendByte(8'h01); sendByte(8'h7E); sendByte(8'h7F);
    idleCycles(2);
    checkOutput("rst_drain_pre_valid", int'(out_valid), 1);
    rx_data = SYNC;
    rx_done = 1'b1;
    rst = 1'b1;
    idleCycles(1);
    checkOutput("rst_drain_valid", int'(out_valid), 0);
    checkOutput("rst_drain_data",  int'(out_data), 0);
    checkOutput("rst_drain_last",  int'(out_last), 0);
    checkOutput("rst_drain_pulses", int'({crc_err, len_err, timeout, overrun}), 0);
    idleCycles(2);
    rst = 1'b0;
    idleCycles(3);
    rx_done = 1'b0;
    setReady(0, 1'b1);
    idleCycles(1);
    nxfer = 0;
    sendByte(8'h02); sendByte(8'h01); sendByte(8'h02); sendByte(8'h05);
    idleCycles(6);
    checkOutput("rst_held_no_event", nxfer, 0);
    pushFrame(8'h11, 8'h22, 2);
    exp_q[1] = {1'b0, 8'h22};
    exp_q.push_back({1'b1, 8'h33});
    sendByte(8'hA5); sendByte(8'h03); sendByte(8'h11); sendByte(8'h22); sendByte(8'h33); sendByte(8'h69);
    waitDrain(20);
    checkCounts("reset");

    // Randomized frames against the frame-level model, random consumer readiness.
    setReady(1, 1'b1);
    for (int f = 0; f < 30; f++) begin
      int         nnoise;
      int         kind;
      int         plen;
      logic [7:0] b;
      logic [7:0] csum;
      logic [7:0] pl [8];
      nnoise = $urandom_range(0, 2);
      for (int i = 0; i < nnoise; i++) begin
        b = 8'($urandom_range(0, 255));
        if (b == SYNC) b = 8'h00;
        sendByte(b);
        idleCycles($urandom_range(0, 3));
      end
      kind = $urandom_range(0, 9);
      sendByte(SYNC);
      idleCycles($urandom_range(0, 3));
      if (kind >= 8) begin
        b = (kind == 8) ? 8'h00 : 8'($urandom_range(9, 255));
        exp_len++;
        sendByte(b);
      end else begin
        plen = $urandom_range(1, 8);
        csum = 8'(plen);
        sendByte(8'(plen));
        idleCycles($urandom_range(0, 3));
        for (int i = 0; i < plen; i++) begin
          pl[i] = 8'($urandom_range(0, 255));
          csum  = csum + pl[i];
          sendByte(pl[i]);
          idleCycles($urandom_range(0, 3));
        end
        if (kind <= 5) begin
          for (int i = 0; i < plen; i++) exp_q.push_back({1'(i == plen - 1), pl[i]});
          sendByte(csum);
        end else begin
          exp_crc++;
          sendByte(csum ^ 8'($urandom_range(1, 255)));
        end
      end
      waitDrain(400);
      checkOutput($sformatf("rand%0d_drained", f), exp_q.size(), 0);
    end
    setReady(0, 1'b1);
    idleCycles(4);
    checkCounts("random");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
